// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int ss_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: fires on the last clk cycle of every CLK_DIV-cycle period while enabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Held at reload while disabled so the first period after leaving IDLE is full length.
  always_ff @(posedge clk) begin
    if (!rst || !en || cnt == '0) cnt <= RELOAD;
    else                          cnt <= cnt - CW'(1);
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// SPI master: one word per request, all four CPOL/CPHA modes, MSB/LSB-first, NUM_SS active-low selects.
//   state | meaning
//   IDLE  | waiting for a request, selects released
//   LEAD  | select asserted, sclk at idle level for one half-period
//   XFER  | 2*DATA_W sclk half-periods, one edge at the start of each
//   TRAIL | sclk back at CPOL for one half-period before release
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  NUM_SS  = 1,
  parameter int  CLK_DIV = 4,
  localparam int SS_W    = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   tx_ss,
  input  logic [1:0]        tx_mode,
  input  logic              tx_lsb_first,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  spi_state_e        state, state_nxt;
  spi_mode_t         mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [EW-1:0]     edge_cnt, edge_num;
  logic [NUM_SS-1:0] ss_dec;
  logic              tick, accept, xfer_done, sclk_edge, odd_edge, present, sample;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  assign tx_ready  = (state == IDLE);
  assign busy      = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign edge_num  = edge_cnt + EW'(1);
  assign odd_edge  = edge_num[0];
  assign xfer_done = (state == XFER) && (edge_cnt == LAST_EDGE);
  assign sclk_edge = tick && ((state == LEAD) || ((state == XFER) && !xfer_done));

  // CPHA=0 loads the first bit at accept, so the final trailing edge has nothing left to shift.
  assign present = sclk_edge && (mode_q.cpha ? odd_edge
                                             : (!odd_edge && edge_num != LAST_EDGE));
  assign sample  = sclk_edge && (mode_q.cpha ? !odd_edge : odd_edge);

  // An out-of-range index matches no select line.
  always_comb begin
    ss_dec = '0;
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = (tx_ss == SS_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = LEAD;
      LEAD:    if (tick)             state_nxt = XFER;
      XFER:    if (tick && xfer_done) state_nxt = TRAIL;
      TRAIL:   if (tick)             state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q   <= '0;
      lsb_q    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        mode_q   <= spi_mode_t'(tx_mode);
        lsb_q    <= tx_lsb_first;
        edge_cnt <= '0;
        rx_sh    <= '0;
        sclk     <= tx_mode[1];
        ss_n     <= ~ss_dec;
        if (!tx_mode[0]) begin
          mosi  <= tx_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          tx_sh <= tx_lsb_first ? (tx_data >> 1) : (tx_data << 1);
        end else begin
          tx_sh <= tx_data;
        end
      end else begin
        if (sclk_edge) begin
          sclk     <= odd_edge ? ~mode_q.cpol : mode_q.cpol;
          edge_cnt <= edge_num;
        end
        if (present) begin
          mosi  <= lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
          tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        end
        if (sample)
          rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        if ((state == TRAIL) && tick) begin
          ss_n     <= '1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: table-driven and random transfers against a protocol-level SPI slave model.
module tb_spi_master_param;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int CD = 2;
  localparam int SSW = 2;
  localparam int LOW_CYCLES = (2 * DW + 2) * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic [SSW-1:0] tx_ss = '0;
  logic [1:0]    tx_mode = '0;
  logic          tx_lsb_first = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic [NS-1:0] ss_n;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(DW), .NUM_SS(NS), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_ss(tx_ss), .tx_mode(tx_mode), .tx_lsb_first(tx_lsb_first), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave configuration, set by the driver before each request.
  bit            cpol = 0, cpha = 0, cur_lsb = 0, loopback = 0;
  logic [DW-1:0] slave_word = '0;
  logic          slave_miso = 1'b0;

  assign miso = loopback ? mosi : slave_miso;

  typedef struct {
    int            low;
    int            edges;
    int            rises;
    int            gap;
    logic [NS-1:0] mask;
    logic [DW-1:0] seen;
    logic          first;
  } sel_rec_t;

  sel_rec_t      dq[$];
  logic [DW-1:0] rxq[$];
  sel_rec_t      cur;
  logic          prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic [NS-1:0] prev_ss = '1;
  int            high_run = 1000, bit_rx = 0, bit_tx = 0;

  function automatic logic seq_bit(input logic [DW-1:0] w, input int k, input bit lsb);
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  // Protocol-level slave: samples and shifts on sclk edges chosen by CPOL/CPHA.
  always @(negedge clk) begin
    if (ss_n != '1 && prev_ss == '1) begin
      cur.low = 1; cur.edges = 0; cur.rises = 0; cur.mask = ~ss_n;
      cur.seen = '0; cur.first = 1'b0; cur.gap = high_run;
      high_run = 0; bit_rx = 0; bit_tx = 0;
      if (!cpha) begin
        slave_miso = seq_bit(slave_word, 0, cur_lsb);
        bit_tx = 1;
      end
    end else if (ss_n != '1) begin
      cur.low++;
      cur.mask |= ~ss_n;
      if (sclk != prev_sclk) begin
        cur.edges++;
        if (sclk) cur.rises++;
        if ((prev_sclk == cpol) != cpha) begin
          if (bit_rx < DW) begin
            if (cur_lsb) cur.seen[bit_rx] = prev_mosi;
            else         cur.seen[DW-1-bit_rx] = prev_mosi;
            if (bit_rx == 0) cur.first = prev_mosi;
            bit_rx++;
          end
        end else if (bit_tx < DW) begin
          slave_miso = seq_bit(slave_word, bit_tx, cur_lsb);
          bit_tx++;
        end
      end
    end else begin
      high_run++;
      if (prev_ss != '1) dq.push_back(cur);
    end
    if (rx_valid) rxq.push_back(rx_data);
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_ss   = ss_n;
  end

  task automatic setup(input logic [1:0] mode, input bit lsb, input logic [SSW-1:0] ss,
                       input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit loop);
    cpol = mode[1]; cpha = mode[0]; cur_lsb = lsb; slave_word = sw; loopback = loop;
    tx_mode = mode; tx_lsb_first = lsb; tx_ss = ss; tx_data = tx;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int n = 0; n < 400 && dq.size() < target; n++) @(posedge clk);
    #1;
    if (dq.size() < target) chk({tag, "_timeout"}, dq.size(), target);
  endtask

  task automatic do_xfer(input logic [1:0] mode, input bit lsb, input logic [SSW-1:0] ss,
                         input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit loop,
                         input logic [DW-1:0] exp_rx, input string tag);
    int d0, r0;
    d0 = dq.size();
    r0 = rxq.size();
    @(posedge clk); #1;
    setup(mode, lsb, ss, tx, sw, loop);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(d0 + 1, tag);
    if (dq.size() > d0) begin
      chk({tag, "_seen"}, dq[d0].seen, tx);
      chk({tag, "_first"}, dq[d0].first, lsb ? tx[0] : tx[DW-1]);
      chk({tag, "_ss_low"}, dq[d0].low, LOW_CYCLES);
      chk({tag, "_edges"}, dq[d0].edges, 2 * DW);
      chk({tag, "_rises"}, dq[d0].rises, DW);
      chk({tag, "_mask"}, dq[d0].mask, 4'b0001 << ss);
    end
    chk({tag, "_rxv_count"}, rxq.size() - r0, 1);
    if (rxq.size() > r0) chk({tag, "_rx"}, rxq[r0], exp_rx);
    chk({tag, "_sclk_idle"}, sclk, mode[1]);
    chk({tag, "_idle"}, {busy, tx_ready}, 2'b01);
  endtask

  typedef struct {
    logic [1:0]     mode;
    bit             lsb;
    logic [SSW-1:0] ss;
    logic [DW-1:0]  tx;
    logic [DW-1:0]  sw;
    bit             loop;
    logic [DW-1:0]  exp_rx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, r0;
    vecs[0] = '{2'd0, 0, 2'd0, 8'hA5, 8'h00, 1, 8'hA5};
    vecs[1] = '{2'd3, 0, 2'd0, 8'h81, 8'h3C, 0, 8'h3C};
    vecs[2] = '{2'd1, 0, 2'd1, 8'h81, 8'h3C, 0, 8'h3C};
    vecs[3] = '{2'd2, 0, 2'd0, 8'h81, 8'h3C, 0, 8'h3C};
    vecs[4] = '{2'd0, 1, 2'd0, 8'h01, 8'h80, 0, 8'h80};
    vecs[5] = '{2'd3, 1, 2'd3, 8'hC4, 8'h96, 0, 8'h96};
    vecs[6] = '{2'd1, 1, 2'd2, 8'h6E, 8'h00, 1, 8'h6E};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ss_n", ss_n, 4'hF);
    chk("reset_sclk_mosi", {sclk, mosi}, 2'b00);
    chk("reset_busy_ready", {busy, tx_ready}, 2'b01);
    chk("reset_rx", {rx_valid, rx_data}, 9'h000);
    rst = 1'b1;

    foreach (vecs[i])
      do_xfer(vecs[i].mode, vecs[i].lsb, vecs[i].ss, vecs[i].tx, vecs[i].sw,
              vecs[i].loop, vecs[i].exp_rx, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic [1:0] m;
      bit l, lp;
      logic [SSW-1:0] s;
      logic [DW-1:0] t, w;
      m = 2'($urandom_range(0, 3));
      l = 1'($urandom_range(0, 1));
      lp = ($urandom_range(0, 3) == 0);
      s = SSW'($urandom_range(0, NS - 1));
      t = DW'($urandom);
      w = DW'($urandom);
      do_xfer(m, l, s, t, w, lp, lp ? t : w, $sformatf("rnd%0d", i));
    end

    // Requests held during a transfer must not disturb the latched word.
    d0 = dq.size();
    @(posedge clk); #1;
    setup(2'd0, 0, 2'd1, 8'h3C, 8'h55, 0);
    tx_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (tx_ready) break;
      tx_data = DW'($urandom);
    end
    tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_count", dq.size() - d0, 1);
    if (dq.size() > d0) chk("hold_seen", dq[d0].seen, 8'h3C);
    chk("hold_idle", busy, 0);

    // Back-to-back with tx_valid held across the completion cycle.
    d0 = dq.size();
    r0 = rxq.size();
    @(posedge clk); #1;
    setup(2'd0, 0, 2'd2, 8'h11, 8'h5A, 0);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_ss = 2'd3;
    tx_data = 8'h22;
    for (int n = 0; n < 200 && !tx_ready; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("b2b_second_accept", busy, 1);
    wait_done(d0 + 2, "b2b");
    if (dq.size() >= d0 + 2) begin
      chk("b2b_mask0", dq[d0].mask, 4'b0100);
      chk("b2b_mask1", dq[d0+1].mask, 4'b1000);
      chk("b2b_gap", dq[d0+1].gap, 1);
      chk("b2b_seen0", dq[d0].seen, 8'h11);
      chk("b2b_seen1", dq[d0+1].seen, 8'h22);
      chk("b2b_low1", dq[d0+1].low, LOW_CYCLES);
    end
    chk("b2b_rxv_count", rxq.size() - r0, 2);
    if (rxq.size() >= r0 + 2) chk("b2b_rx", {rxq[r0], rxq[r0+1]}, 16'h5A5A);

    // Reset after three bits of a mode-0 transfer.
    r0 = rxq.size();
    @(posedge clk); #1;
    setup(2'd0, 0, 2'd0, 8'hFF, 8'hFF, 0);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (CD + 6 * CD) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_ss_n", ss_n, 4'hF);
    chk("abort_sclk_mosi", {sclk, mosi}, 2'b00);
    chk("abort_busy_ready", {busy, tx_ready}, 2'b01);
    chk("abort_rx", {rx_valid, rx_data}, 9'h000);
    repeat (LOW_CYCLES + 10) @(posedge clk);
    #1;
    chk("abort_no_rxv", rxq.size() - r0, 0);
    do_xfer(2'd0, 0, 2'd0, 8'h5A, 8'hC3, 0, 8'hC3, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master for the SPI-DSD design; successor to the fixed 4-bit data path.
- Accepts one word per transaction over a valid/ready request port and supports all four SPI modes (CPOL/CPHA), MSB- or LSB-first ordering, a programmable SCLK divider and NUM_SS slave selects.
- Returns the received word with a one-cycle rx_valid pulse. Sits between the system-side controller and external SPI pins.

Parameters:
- DATA_W, 8, bits per transfer (>=2).
- NUM_SS, 1, number of active-low slave selects (>=1).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- SS_W, max(1,$clog2(NUM_SS)), width of the slave index (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- tx_valid  in  1  request valid.
- tx_ready  out  1  high only in IDLE.
- tx_data  in  DATA_W  word to send.
- tx_ss  in  SS_W  slave index.
- tx_mode  in  2  {CPOL,CPHA}.
- tx_lsb_first  in  1  1 = LSB shifted first.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- rx_data  out  DATA_W  received word, held until the next rx_valid.
- busy  out  1  high when not IDLE.
- sclk  out  1  SPI clock.
- mosi  out  1  serial out.
- miso  in  1  serial in.
- ss_n  out  NUM_SS  active-low selects.

Behaviour:
- Reset (rst=0 at an edge), including mid-transfer:
  - State goes to IDLE; latched mode = 0.
  - sclk=0, mosi=0, ss_n=all 1, rx_valid=0, rx_data=0, busy=0, tx_ready=1.
  - No rx_valid is produced for the aborted word.
- Accept: tx_valid&&tx_ready at edge T0.
  - Latch tx_data, tx_ss, tx_mode and tx_lsb_first.
  - Inputs are ignored until the next IDLE.
  - From T0: ss_n[tx_ss]=0, sclk=CPOL, busy=1, tx_ready=0.
  - tx_ss>=NUM_SS: no select asserts; the transfer otherwise runs normally.
- FSM states IDLE -> LEAD -> XFER -> TRAIL -> IDLE:
  - LEAD lasts CLK_DIV cycles, with SCLK idle.
  - XFER has 2*DATA_W half-periods of CLK_DIV cycles each; sclk toggles at the start of each half-period, so there are 2*DATA_W edges.
  - TRAIL lasts CLK_DIV cycles; SCLK is back at CPOL.
- First-bit and shift rules:
  - First bit is tx_data[DATA_W-1], or tx_data[0] when lsb_first.
  - CPHA=0: first bit on mosi from T0; miso sampled on each odd (leading) edge; mosi advances on each even (trailing) edge except the last.
  - CPHA=1: mosi presents the first bit at edge 1 and advances on each odd edge; miso sampled on each even edge.
- Received data ordering:
  - Bits assemble so that rx_data equals the slave's word in the same bit order.
  - lsb_first: first bit received -> rx_data[0].
- Completion:
  - The first IDLE cycle after TRAIL has ss_n all 1, rx_valid=1, rx_data updated, busy=0 and tx_ready=1.
  - ss_n is low for exactly (2*DATA_W+2)*CLK_DIV cycles.
- Back-to-back: a request accepted in the completion cycle starts at the next edge. ss_n is therefore high for at least 1 cycle between transfers.
- Divider:
  - The counter runs only outside IDLE and reloads on every state/half-period boundary.
  - CLK_DIV=1 gives SCLK = clk/2.
- mosi in IDLE holds its last value; after reset it is 0.

Decomposition:
- spi_pkg holds:
  - typedef spi_state_e {IDLE, LEAD, XFER, TRAIL};
  - typedef spi_mode_t (packed struct cpol, cpha);
  - the SS_W helper function.
- Sub-module spi_clk_div generates the half-period tick:
  - ports clk, rst, en, tick;
  - parameter CLK_DIV.
- The top module contains the FSM, shift registers, select decode and edge counter (counts 0..2*DATA_W).

Test Plan:
- Mode 0 loopback: DATA_W=8, CLK_DIV=2, miso=mosi, tx 0xA5 -> rx_data=0xA5, ss_n[0] low 36 cycles, 8 rising sclk edges, sclk idles 0.
- Mode 3 slave model returning 0x3C, MSB-first, tx 0x81 -> model sees 0x81, rx_data=0x3C, sclk idles 1; repeat for modes 1 and 2.
- lsb_first with tx 0x01 -> first mosi bit 1, remaining bits 0; slave sends 0x80 LSB-first -> rx_data=0x80.
- NUM_SS=4, tx_ss=2 then tx_ss=3 back-to-back with tx_valid held:
  - only ss_n[2] then only ss_n[3] low;
  - exactly 1 idle cycle of ss_n=4'hF between them;
  - two rx_valid pulses.
- Busy/ignore: tx_valid held with changing tx_data during a transfer -> no accept until tx_ready; the latched word is sent unchanged.
- Reset mid-XFER after 3 bits (rst=0 one cycle) -> next cycle ss_n all 1, sclk=0, busy=0, no rx_valid; a fresh 0x5A transfer then completes correctly.
